// File: rtl/io_sequencer.sv
// UART I/O sequencer: stalls the PC while an IN instruction waits for a received
// byte or an OUT instruction waits for the transmitter, and buffers received bytes.
module io_sequencer #(
  parameter int unsigned RXBUF_DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic                           in_req,
  input  logic                           out_req,
  input  logic [7:0]                     out_data,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_byte,
  input  logic                           tx_busy,
  output logic                           tx_start,
  output logic [7:0]                     tx_byte,
  output logic                           reg_we,
  output logic [31:0]                    reg_wdata,
  output logic                           pc_enable,
  output logic [$clog2(RXBUF_DEPTH):0]   rx_count,
  output logic                           rx_overrun
);

  localparam int unsigned AW = $clog2(RXBUF_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(RXBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, IN_WAIT, OUT_WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    rx_mem [RXBUF_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          pop, push, send;

  assign pop  = (state == IN_WAIT) && (rx_count != '0);
  assign send = (state == OUT_WAIT) && !tx_busy;
  // A full buffer still accepts a byte when the head is popped in the same cycle.
  assign push = rx_valid && ((rx_count != FULL_COUNT) || pop);

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_req)       state_nxt = IN_WAIT;
        else if (out_req) state_nxt = OUT_WAIT;
      end
      IN_WAIT:  if (pop)  state_nxt = DONE;
      OUT_WAIT: if (send) state_nxt = DONE;
      DONE:               state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_enable = 1'b0;
    if ((state == IDLE && !in_req && !out_req) || state == DONE) pc_enable = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      reg_we    <= 1'b0;
      reg_wdata <= '0;
      tx_start  <= 1'b0;
      tx_byte   <= '0;
    end else begin
      reg_we   <= pop;
      tx_start <= send;
      if (pop)  reg_wdata <= {24'b0, rx_mem[rd_ptr]};
      if (send) tx_byte   <= out_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rx_valid && !push) rx_overrun <= 1'b1;
      case ({push, pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset && push) rx_mem[wr_ptr] <= rx_byte;
  end

endmodule

// File: tb/tb_io_sequencer.sv
// Directed self-checking bench for io_sequencer with hand-computed expectations.
module tb_io_sequencer;

  logic        CLK = 1'b0;
  logic        reset, in_req, out_req, rx_valid, tx_busy;
  logic [7:0]  out_data, rx_byte;
  logic        tx_start, reg_we, pc_enable, rx_overrun;
  logic [7:0]  tx_byte;
  logic [31:0] reg_wdata;
  logic [2:0]  rx_count;

  int checks = 0;
  int errors = 0;

  io_sequencer #(.RXBUF_DEPTH(4)) dut (
    .CLK(CLK), .reset(reset), .in_req(in_req), .out_req(out_req),
    .out_data(out_data), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
    .reg_we(reg_we), .reg_wdata(reg_wdata), .pc_enable(pc_enable),
    .rx_count(rx_count), .rx_overrun(rx_overrun)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_req = 1'b0; out_req = 1'b0; out_data = '0;
    rx_valid = 1'b0; rx_byte = '0; tx_busy = 1'b0;
    do_reset();
    checks++; if ({tx_start, reg_we, rx_overrun} !== 3'b000) begin errors++;
      $display("FAIL reset_pulses: got %b expected 000", {tx_start, reg_we, rx_overrun}); end
    checks++; if (reg_wdata !== 32'h0 || tx_byte !== 8'h00) begin errors++;
      $display("FAIL reset_data: got %h/%h expected 0/0", reg_wdata, tx_byte); end
    checks++; if (rx_count !== 3'd0 || pc_enable !== 1'b1) begin errors++;
      $display("FAIL reset_idle: count %0d pc_enable %b expected 0 1", rx_count, pc_enable); end
  endtask

  task automatic test_in_ready();
    rx_valid = 1'b1; rx_byte = 8'h41;
    step();
    rx_valid = 1'b0;
    checks++; if (rx_count !== 3'd1) begin errors++;
      $display("FAIL s1_push: count %0d expected 1", rx_count); end
    in_req = 1'b1;
    #1;
    checks++; if (pc_enable !== 1'b0) begin errors++;
      $display("FAIL s1_pc_c0: got %b expected 0", pc_enable); end
    step();
    checks++; if (pc_enable !== 1'b0 || reg_we !== 1'b0) begin errors++;
      $display("FAIL s1_c1: pc_enable %b reg_we %b expected 0 0", pc_enable, reg_we); end
    step();
    checks++; if (reg_we !== 1'b1 || reg_wdata !== 32'h00000041) begin errors++;
      $display("FAIL s1_write: reg_we %b data %h expected 1 00000041", reg_we, reg_wdata); end
    checks++; if (pc_enable !== 1'b1 || rx_count !== 3'd0) begin errors++;
      $display("FAIL s1_done: pc_enable %b count %0d expected 1 0", pc_enable, rx_count); end
    in_req = 1'b0;
    step();
    checks++; if (reg_we !== 1'b0 || reg_wdata !== 32'h00000041 || pc_enable !== 1'b1) begin errors++;
      $display("FAIL s1_idle: reg_we %b data %h pc %b expected 0 00000041 1", reg_we, reg_wdata, pc_enable); end
  endtask

  task automatic test_in_wait();
    int pulses = 0;
    int stalls_bad = 0;
    in_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pc_enable !== 1'b0) stalls_bad++;
      if (reg_we) pulses++;
    end
    checks++; if (stalls_bad != 0) begin errors++;
      $display("FAIL s2_stall: pc_enable high in %0d cycles expected 0", stalls_bad); end
    rx_valid = 1'b1; rx_byte = 8'h7F;
    step();
    rx_valid = 1'b0;
    checks++; if (rx_count !== 3'd1 || pc_enable !== 1'b0) begin errors++;
      $display("FAIL s2_arrive: count %0d pc %b expected 1 0", rx_count, pc_enable); end
    step();
    checks++; if (reg_we !== 1'b1 || reg_wdata !== 32'h0000007F) begin errors++;
      $display("FAIL s2_write: reg_we %b data %h expected 1 0000007F", reg_we, reg_wdata); end
    pulses += int'(reg_we);
    in_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (reg_we) pulses++;
    end
    checks++; if (pulses != 1) begin errors++;
      $display("FAIL s2_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_out_wait();
    int starts = 0;
    int bad = 0;
    out_data = 8'h55; tx_busy = 1'b1; out_req = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      if (pc_enable !== 1'b0) bad++;
      if (tx_start) starts++;
    end
    checks++; if (bad != 0 || starts != 0) begin errors++;
      $display("FAIL s3_busy: pc high %0d starts %0d expected 0 0", bad, starts); end
    tx_busy = 1'b0;
    step();
    checks++; if (tx_start !== 1'b1 || tx_byte !== 8'h55 || pc_enable !== 1'b1) begin errors++;
      $display("FAIL s3_send: start %b byte %h pc %b expected 1 55 1", tx_start, tx_byte, pc_enable); end
    out_req = 1'b0; out_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      if (tx_start) starts++;
    end
    checks++; if (starts != 0 || tx_byte !== 8'h55) begin errors++;
      $display("FAIL s3_after: extra starts %0d byte %h expected 0 55", starts, tx_byte); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    do_reset();
    rx_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      rx_byte = 8'(i);
      step();
    end
    rx_valid = 1'b0;
    checks++; if (rx_count !== 3'd4 || rx_overrun !== 1'b1) begin errors++;
      $display("FAIL s4_full: count %0d overrun %b expected 4 1", rx_count, rx_overrun); end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      in_req = 1'b1;
      step();
      step();
      checks++; if (reg_we !== 1'b1 || reg_wdata !== {24'h0, exp}) begin errors++;
        $display("FAIL s4_pop%0d: reg_we %b data %h expected 1 %h", i, reg_we, reg_wdata, {24'h0, exp}); end
      in_req = 1'b0;
      step();
    end
    checks++; if (rx_count !== 3'd0 || rx_overrun !== 1'b1) begin errors++;
      $display("FAIL s4_sticky: count %0d overrun %b expected 0 1", rx_count, rx_overrun); end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp_q [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h99};
    do_reset();
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_byte = exp_q[i];
      step();
    end
    rx_valid = 1'b0;
    in_req = 1'b1;
    step();
    rx_valid = 1'b1; rx_byte = 8'h99;
    step();
    rx_valid = 1'b0;
    checks++; if (reg_we !== 1'b1 || reg_wdata !== 32'h000000A1) begin errors++;
      $display("FAIL s5_head: reg_we %b data %h expected 1 000000A1", reg_we, reg_wdata); end
    checks++; if (rx_count !== 3'd4 || rx_overrun !== 1'b0) begin errors++;
      $display("FAIL s5_count: count %0d overrun %b expected 4 0", rx_count, rx_overrun); end
    in_req = 1'b0;
    step();
    for (int i = 1; i < 5; i++) begin
      in_req = 1'b1;
      step();
      step();
      checks++; if (reg_wdata !== {24'h0, exp_q[i]}) begin errors++;
        $display("FAIL s5_drain%0d: data %h expected %h", i, reg_wdata, {24'h0, exp_q[i]}); end
      in_req = 1'b0;
      step();
    end
  endtask

  task automatic test_priority_reset();
    int starts = 0;
    do_reset();
    rx_valid = 1'b1; rx_byte = 8'h33;
    step();
    rx_valid = 1'b0;
    in_req = 1'b1; out_req = 1'b1; out_data = 8'hC3; tx_busy = 1'b1;
    step();
    step();
    checks++; if (reg_we !== 1'b1 || reg_wdata !== 32'h00000033 || tx_start !== 1'b0) begin errors++;
      $display("FAIL s6_in_first: reg_we %b data %h start %b expected 1 00000033 0", reg_we, reg_wdata, tx_start); end
    in_req = 1'b0;
    step();
    step();
    step();
    checks++; if (pc_enable !== 1'b0) begin errors++;
      $display("FAIL s6_out_wait: pc_enable %b expected 0", pc_enable); end
    reset = 1'b1; tx_busy = 1'b0; rx_valid = 1'b1; rx_byte = 8'hEE;
    step();
    reset = 1'b0; rx_valid = 1'b0; out_req = 1'b0;
    #1;
    checks++; if ({tx_start, reg_we, rx_overrun} !== 3'b000 || reg_wdata !== 32'h0 || tx_byte !== 8'h00) begin errors++;
      $display("FAIL s6_reset_out: pulses %b data %h byte %h expected 000 0 0", {tx_start, reg_we, rx_overrun}, reg_wdata, tx_byte); end
    checks++; if (rx_count !== 3'd0 || pc_enable !== 1'b1) begin errors++;
      $display("FAIL s6_reset_idle: count %0d pc %b expected 0 1", rx_count, pc_enable); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (tx_start || reg_we) starts++;
    end
    checks++; if (starts != 0) begin errors++;
      $display("FAIL s6_no_pulse: got %0d pulses expected 0", starts); end
  endtask

  initial begin
    test_reset();
    test_in_ready();
    test_in_wait();
    test_out_wait();
    test_overrun();
    test_full_pop_push();
    test_priority_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
